vec3_alu_pipe: RTL and testbench

Pipelined, parametrised fixed-point vec3 arithmetic unit for the ray-marcher datapath. It executes one of six vector operations per accepted transaction: add, sub, neg, scale, dot and cross. Valid/ready handshakes sit on both sides, and a user tag travels with each transaction. It replaces ad-hoc combinational vector functions with a registered, throughput-1 unit that the marcher FSM and normal-estimation stages can share.

---
 rtl/vec3_pkg.sv | 23 ++
 rtl/vec3_alu_pipe_fx_mul.sv | 32 +++
 rtl/vec3_alu_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_vec3_alu_pipe.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec3_pkg.sv
// Shared opcode encoding and flat-vector slicing helper for the vec3 ALU.
// Build option VEC3_ALU_SAT_EN (saturating arithmetic) is handled in vec3_alu_pipe and fx_mul.
package vec3_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_NEG   = 3'd2,
        OP_SCALE = 3'd3,
        OP_DOT   = 3'd4,
        OP_CROSS = 3'd5
    } vec3_op_t;

    localparam int VEC3_X = 0;
    localparam int VEC3_Y = 1;
    localparam int VEC3_Z = 2;

    // Bit offset of component idx (0 = x) inside a flat {x,y,z} vector; x sits in the MSBs.
    function automatic int vec3_lsb(input int width, input int idx);
        return (2 - idx) * width;
    endfunction

endpackage

// File: rtl/vec3_alu_pipe_fx_mul.sv
// fx_mul: combinational signed fixed-point multiply with overflow flag.
// With VEC3_ALU_SAT_EN defined an overflowing product saturates instead of wrapping.
module fx_mul #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r,
    output logic             ovf
);

    logic        [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] shifted;
    logic        [WIDTH:0]     hi;

    // Low 2*WIDTH bits of the product of sign-extended operands equal the signed product.
    assign prod    = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign shifted = $signed(prod) >>> FRAC_BITS;
    assign hi      = shifted[2*WIDTH-1:WIDTH-1];
    assign ovf     = !((&hi) || !(|hi));

`ifdef VEC3_ALU_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    assign r = ovf ? (prod[2*WIDTH-1] ? SMIN : SMAX) : shifted[WIDTH-1:0];
`else
    assign r = shifted[WIDTH-1:0];
`endif

endmodule

// File: rtl/vec3_alu_pipe.sv
// vec3_alu_pipe: two-stage pipelined fixed-point vec3 unit (add/sub/neg/scale/dot/cross).
// Build option VEC3_ALU_SAT_EN saturates overflowing results; default build wraps.
module vec3_alu_pipe
    import vec3_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 16,
    parameter int TAG_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [3*WIDTH-1:0]   in_a,
    input  logic [3*WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3*WIDTH-1:0]   out_r,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_ovf
);

`ifdef VEC3_ALU_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    function automatic logic [WIDTH:0] ext1(input logic [WIDTH-1:0] v);
        return {v[WIDTH-1], v};
    endfunction

    function automatic logic [WIDTH+1:0] ext2(input logic [WIDTH-1:0] v);
        return {{2{v[WIDTH-1]}}, v};
    endfunction

    // Narrow a WIDTH+1 result to WIDTH; returns {ovf, value}.
    function automatic logic [WIDTH:0] narrow1(input logic [WIDTH:0] v);
        logic o;
        o = v[WIDTH] ^ v[WIDTH-1];
`ifdef VEC3_ALU_SAT_EN
        if (o) return {1'b1, (v[WIDTH] ? SMIN : SMAX)};
`endif
        return {o, v[WIDTH-1:0]};
    endfunction

    // Narrow a WIDTH+2 three-term sum to WIDTH; returns {ovf, value}.
    function automatic logic [WIDTH:0] narrow2(input logic [WIDTH+1:0] v);
        logic o;
        o = !((&v[WIDTH+1:WIDTH-1]) || !(|v[WIDTH+1:WIDTH-1]));
`ifdef VEC3_ALU_SAT_EN
        if (o) return {1'b1, (v[WIDTH+1] ? SMIN : SMAX)};
`endif
        return {o, v[WIDTH-1:0]};
    endfunction

    logic [WIDTH-1:0] a_c [3];
    logic [WIDTH-1:0] b_c [3];

    for (genvar i = 0; i < 3; i++) begin : g_unpack
        assign a_c[i] = in_a[vec3_lsb(WIDTH, i) +: WIDTH];
        assign b_c[i] = in_b[vec3_lsb(WIDTH, i) +: WIDTH];
    end

    logic [5:0][WIDTH-1:0] ma, mb, mr;
    logic [5:0]            mo;

    // Unused multipliers see zero operands so their ovf stays low.
    always_comb begin
        ma = '0;
        mb = '0;
        case (in_op)
            OP_SCALE: begin
                for (int i = 0; i < 3; i++) begin
                    ma[i] = a_c[i];
                    mb[i] = b_c[VEC3_X];
                end
            end
            OP_DOT: begin
                for (int i = 0; i < 3; i++) begin
                    ma[i] = a_c[i];
                    mb[i] = b_c[i];
                end
            end
            OP_CROSS: begin
                ma[0] = a_c[VEC3_Y]; mb[0] = b_c[VEC3_Z];
                ma[1] = a_c[VEC3_Z]; mb[1] = b_c[VEC3_Y];
                ma[2] = a_c[VEC3_Z]; mb[2] = b_c[VEC3_X];
                ma[3] = a_c[VEC3_X]; mb[3] = b_c[VEC3_Z];
                ma[4] = a_c[VEC3_X]; mb[4] = b_c[VEC3_Y];
                ma[5] = a_c[VEC3_Y]; mb[5] = b_c[VEC3_X];
            end
            default: ;
        endcase
    end

    for (genvar i = 0; i < 6; i++) begin : g_mul
        fx_mul #(
            .WIDTH     (WIDTH),
            .FRAC_BITS (FRAC_BITS)
        ) u_mul (
            .a   (ma[i]),
            .b   (mb[i]),
            .r   (mr[i]),
            .ovf (mo[i])
        );
    end

    logic [5:0][WIDTH-1:0] p_d;
    logic [5:0]            po_d;

    always_comb begin
        p_d  = mr;
        po_d = mo;
        for (int i = 0; i < 3; i++) begin
            case (in_op)
                OP_ADD:  {po_d[i], p_d[i]} = narrow1(ext1(a_c[i]) + ext1(b_c[i]));
                OP_SUB:  {po_d[i], p_d[i]} = narrow1(ext1(a_c[i]) - ext1(b_c[i]));
                OP_NEG:  {po_d[i], p_d[i]} = narrow1(-ext1(a_c[i]));
                default: ;
            endcase
        end
    end

    logic                  s1_valid, s2_valid;
    logic                  s1_adv, s2_adv;
    logic [2:0]            s1_op;
    logic [TAG_W-1:0]      s1_tag;
    logic [5:0][WIDTH-1:0] s1_p;
    logic [5:0]            s1_po;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_tag   <= '0;
            s1_p     <= '0;
            s1_po    <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op  <= in_op;
                s1_tag <= in_tag;
                s1_p   <= p_d;
                s1_po  <= po_d;
            end
        end
    end

    logic [3*WIDTH-1:0]    r_d;
    logic                  ovf_d;
    logic [WIDTH-1:0]      dx;
    logic                  dxo;
    logic [2:0][WIDTH-1:0] cr;
    logic [2:0]            cro;

    always_comb begin
        r_d   = '0;
        ovf_d = |s1_po;
        {dxo, dx} = narrow2(ext2(s1_p[0]) + ext2(s1_p[1]) + ext2(s1_p[2]));
        for (int i = 0; i < 3; i++) begin
            {cro[i], cr[i]} = narrow1(ext1(s1_p[2*i]) - ext1(s1_p[2*i+1]));
        end
        case (s1_op)
            OP_ADD, OP_SUB, OP_NEG, OP_SCALE: r_d = {s1_p[0], s1_p[1], s1_p[2]};
            OP_DOT: begin
                r_d   = {dx, {(2*WIDTH){1'b0}}};
                ovf_d = ovf_d | dxo;
            end
            OP_CROSS: begin
                r_d   = {cr[0], cr[1], cr[2]};
                ovf_d = ovf_d | (|cro);
            end
            default: begin
                r_d   = '0;
                ovf_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_r    <= '0;
            out_tag  <= '0;
            out_ovf  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_r   <= r_d;
                out_tag <= s1_tag;
                out_ovf <= ovf_d;
            end
        end
    end

endmodule

// File: tb/tb_vec3_alu_pipe.sv
// Self-checking bench for vec3_alu_pipe: directed cases, backpressure, async reset and
// randomized traffic against an integer-arithmetic reference model.
module tb_vec3_alu_pipe;

    localparam int W  = 32;
    localparam int FB = 16;
    localparam int TW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      in_op = '0;
    logic [3*W-1:0]  in_a = '0;
    logic [3*W-1:0]  in_b = '0;
    logic [TW-1:0]   in_tag = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [3*W-1:0]  out_r;
    logic [TW-1:0]   out_tag;
    logic            out_ovf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vec3_alu_pipe #(.WIDTH(W), .FRAC_BITS(FB), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_tag   (out_tag),
        .out_ovf   (out_ovf)
    );

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    localparam longint IMAX = 64'sd2147483647;
    localparam longint IMIN = -64'sd2147483648;

    function automatic void fit(input longint v, output int r, output bit o);
        o = (v > IMAX) || (v < IMIN);
        r = int'(v);
`ifdef VEC3_ALU_SAT_EN
        if (o) r = (v < 0) ? int'(IMIN) : int'(IMAX);
`endif
    endfunction

    function automatic void fmul(input int a, input int b, output int r, output bit o);
        longint p;
        p = longint'(a) * longint'(b);
        fit(p >>> FB, r, o);
    endfunction

    typedef struct {
        logic [3*W-1:0] r;
        logic [TW-1:0]  tag;
        logic           ovf;
    } exp_t;

    function automatic exp_t model(input logic [2:0] op, input logic [3*W-1:0] va,
                                   input logic [3*W-1:0] vb, input logic [TW-1:0] tag);
        int a[3], b[3], r[3], p[6];
        bit o, ov;
        longint s;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            a[i] = int'(va[(2-i)*W +: W]);
            b[i] = int'(vb[(2-i)*W +: W]);
            r[i] = 0;
        end
        ov = 0;
        case (op)
            3'd0: for (int i = 0; i < 3; i++) begin fit(longint'(a[i]) + b[i], r[i], o); ov |= o; end
            3'd1: for (int i = 0; i < 3; i++) begin fit(longint'(a[i]) - b[i], r[i], o); ov |= o; end
            3'd2: for (int i = 0; i < 3; i++) begin fit(-longint'(a[i]), r[i], o); ov |= o; end
            3'd3: for (int i = 0; i < 3; i++) begin fmul(a[i], b[0], r[i], o); ov |= o; end
            3'd4: begin
                s = 0;
                for (int i = 0; i < 3; i++) begin fmul(a[i], b[i], p[i], o); ov |= o; s += p[i]; end
                fit(s, r[0], o); ov |= o;
            end
            3'd5: for (int i = 0; i < 3; i++) begin
                fmul(a[(i+1)%3], b[(i+2)%3], p[2*i], o);   ov |= o;
                fmul(a[(i+2)%3], b[(i+1)%3], p[2*i+1], o); ov |= o;
                fit(longint'(p[2*i]) - p[2*i+1], r[i], o); ov |= o;
            end
            default: ov = 1;
        endcase
        e.r   = {r[0], r[1], r[2]};
        e.tag = tag;
        e.ovf = ov;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_comp();
        logic [W-1:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = {($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000, 16'($urandom)};
            default: begin
                v = $urandom_range(0, 32'h7FFFF);
                v = v - 32'h40000;
            end
        endcase
        return v;
    endfunction

    // ---------------- directed single transaction ----------------
    task automatic directed(input string name, input logic [2:0] op,
                            input logic [3*W-1:0] a, input logic [3*W-1:0] b,
                            input logic [TW-1:0] tag,
                            input logic [3*W-1:0] exp_r, input logic exp_ovf);
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        #1 chk({name, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, lat, 2);
        chk({name, "_r"}, out_r, exp_r);
        chk({name, "_ovf"}, out_ovf, exp_ovf);
        chk({name, "_tag"}, out_tag, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    localparam logic [W-1:0] ONE = 32'h0001_0000;

    initial begin
        exp_t q[$];
        exp_t e;
        int nacc, nxt, seen;
        int got_tags[$], got_cyc[$];
        logic hold_v;
        logic [3*W+TW:0] hold_d;
        logic acc;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_ovf", out_ovf, 0);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1);

        directed("dot", 3'd4, {ONE, 32'h0002_0000, 32'h0003_0000},
                 {32'h0004_0000, 32'h0005_0000, 32'h0006_0000}, 8'h11,
                 {32'h0020_0000, 32'h0, 32'h0}, 1'b0);
        directed("cross", 3'd5, {ONE, 32'h0, 32'h0}, {32'h0, ONE, 32'h0}, 8'h12,
                 {32'h0, 32'h0, ONE}, 1'b0);
        directed("cross_swap", 3'd5, {32'h0, ONE, 32'h0}, {ONE, 32'h0, 32'h0}, 8'h13,
                 {32'h0, 32'h0, 32'hFFFF_0000}, 1'b0);
        directed("scale", 3'd3, {32'h0002_0000, 32'hFFFD_0000, 32'h0000_8000},
                 {32'h0004_0000, 32'h0, 32'h0}, 8'h14,
                 {32'h0008_0000, 32'hFFF4_0000, 32'h0002_0000}, 1'b0);
`ifdef VEC3_ALU_SAT_EN
        directed("scale_ovf", 3'd3, {32'h7FFF_0000, 32'h0, 32'h0}, {32'h0002_0000, 32'h0, 32'h0},
                 8'h15, {32'h7FFF_FFFF, 32'h0, 32'h0}, 1'b1);
        directed("neg_min", 3'd2, {32'h8000_0000, ONE, 32'h0}, '0, 8'h16,
                 {32'h7FFF_FFFF, 32'hFFFF_0000, 32'h0}, 1'b1);
`else
        directed("scale_ovf", 3'd3, {32'h7FFF_0000, 32'h0, 32'h0}, {32'h0002_0000, 32'h0, 32'h0},
                 8'h15, {32'hFFFE_0000, 32'h0, 32'h0}, 1'b1);
        directed("neg_min", 3'd2, {32'h8000_0000, ONE, 32'h0}, '0, 8'h16,
                 {32'h8000_0000, 32'hFFFF_0000, 32'h0}, 1'b1);
`endif
        directed("sub", 3'd1, {32'h0003_0000, 32'h0, 32'hFFFF_0000}, {ONE, ONE, ONE}, 8'h17,
                 {32'h0002_0000, 32'hFFFF_0000, 32'hFFFE_0000}, 1'b0);
        directed("reserved", 3'd6, {ONE, ONE, ONE}, {ONE, ONE, ONE}, 8'h18, '0, 1'b1);

        // backpressure: three back-to-back ADDs with out_ready low
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'd0; in_a = {ONE, ONE, ONE}; in_b = {ONE, 32'h0, 32'h0};
        nacc = 0; nxt = 1;
        for (int c = 0; c < 4; c++) begin
            in_tag = TW'(nxt);
            #1;
            if (in_ready) begin nacc++; nxt++; end
            if (c == 3) chk("bp_in_ready_low", in_ready, 0);
            @(negedge clk);
        end
        chk("bp_accepts", nacc, 2);
        chk("bp_held_tag", in_tag, 3);
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (c == 0) chk("bp_accept3", in_ready, 1);
            if (out_valid) begin
                got_tags.push_back(int'(out_tag));
                got_cyc.push_back(c);
                chk("bp_r", out_r, {32'h0002_0000, ONE, ONE});
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        chk("bp_count", got_tags.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("bp_order", got_tags[i], i + 1);
            chk("bp_cycle", got_cyc[i], i);
        end

        // asynchronous reset with two transactions in flight
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'd0; in_tag = 8'hA1;
        @(negedge clk);
        in_tag = 8'hA2;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_tag", out_tag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1 chk("arst_in_ready", in_ready, 1);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("arst_nothing_emerges", seen, 0);
        directed("dot_after_rst", 3'd4, {ONE, 32'h0002_0000, 32'h0003_0000},
                 {32'h0004_0000, 32'h0005_0000, 32'h0006_0000}, 8'h21,
                 {32'h0020_0000, 32'h0, 32'h0}, 1'b0);

        // randomized traffic against the reference model
        @(negedge clk);
        acc = 1'b1;
        hold_v = 1'b0;
        hold_d = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (hold_v) chk("hold_stable", {out_valid, out_r, out_tag, out_ovf}, {1'b1, hold_d});
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_op    = 3'($urandom_range(0, 7));
                in_a     = {rnd_comp(), rnd_comp(), rnd_comp()};
                in_b     = {rnd_comp(), rnd_comp(), rnd_comp()};
                in_tag   = TW'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("spurious_output", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("rand_r", out_r, e.r);
                    chk("rand_tag", out_tag, e.tag);
                    chk("rand_ovf", out_ovf, e.ovf);
                end
            end
            acc = in_valid && in_ready;
            if (acc) q.push_back(model(in_op, in_a, in_b, in_tag));
            hold_v = out_valid && !out_ready;
            hold_d = {out_r, out_tag, out_ovf};
        end

        // drain
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_valid) begin
                if (q.size() == 0) chk("spurious_output", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("drain_r", out_r, e.r);
                    chk("drain_tag", out_tag, e.tag);
                    chk("drain_ovf", out_ovf, e.ovf);
                end
            end
            @(negedge clk);
        end
        chk("drain_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
